// File: rtl/subtractors_array_pkg.sv
// Shared widths, saturation constant and lane request/response types for the
// ten-lane log-domain normaliser.
package subtractors_array_pkg;

    localparam int XW      = 8;
    localparam int SW      = 9;
    localparam int N_LANES = 10;

    localparam logic [SW-1:0] SAT_MIN = 9'h100;

    typedef struct packed {
        logic [XW-1:0] x;
        logic [SW-1:0] exp_sum;
    } lane_req_t;

    typedef logic [SW-1:0] lane_rsp_t;

endpackage

// File: rtl/subtractors_array_subtractor_unit.sv
// One lane: zero-extend both operands, subtract at SW+1 bits, clamp the
// negative side to SAT_MIN.
module subtractor_unit
    import subtractors_array_pkg::*;
(
    input  lane_req_t req,
    output lane_rsp_t rsp
);

    logic [SW:0] d;

    assign d = {2'b00, req.x} - {1'b0, req.exp_sum};

    // Top two bits 10 means d < -256; the positive side can never exceed 255.
    assign rsp = (d[SW:SW-1] == 2'b10) ? SAT_MIN : d[SW-1:0];

endmodule

// File: rtl/subtractors_array.sv
// Ten subtractor lanes sharing one exp_sum, followed by the output and valid
// registers (single-cycle latency, outputs hold when in_valid is low).
module subtractors_array
    import subtractors_array_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [SW-1:0] exp_sum,
    input  logic [XW-1:0] x1,
    input  logic [XW-1:0] x2,
    input  logic [XW-1:0] x3,
    input  logic [XW-1:0] x4,
    input  logic [XW-1:0] x5,
    input  logic [XW-1:0] x6,
    input  logic [XW-1:0] x7,
    input  logic [XW-1:0] x8,
    input  logic [XW-1:0] x9,
    input  logic [XW-1:0] x10,
    output logic          out_valid,
    output logic [SW-1:0] exp_out1,
    output logic [SW-1:0] exp_out2,
    output logic [SW-1:0] exp_out3,
    output logic [SW-1:0] exp_out4,
    output logic [SW-1:0] exp_out5,
    output logic [SW-1:0] exp_out6,
    output logic [SW-1:0] exp_out7,
    output logic [SW-1:0] exp_out8,
    output logic [SW-1:0] exp_out9,
    output logic [SW-1:0] exp_out10
);

    logic [N_LANES-1:0][XW-1:0] xs;
    logic [N_LANES-1:0][SW-1:0] exp_d;
    logic [N_LANES-1:0][SW-1:0] exp_q;
    logic                       vld_q;

    assign xs = {x10, x9, x8, x7, x6, x5, x4, x3, x2, x1};

    for (genvar g = 0; g < N_LANES; g++) begin : g_lane
        lane_req_t req;
        assign req.x       = xs[g];
        assign req.exp_sum = exp_sum;

        subtractor_unit u_sub (
            .req (req),
            .rsp (exp_d[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
            exp_q <= '0;
        end else begin
            vld_q <= in_valid;
            if (in_valid)
                exp_q <= exp_d;
        end
    end

    assign out_valid = vld_q;
    assign exp_out1  = exp_q[0];
    assign exp_out2  = exp_q[1];
    assign exp_out3  = exp_q[2];
    assign exp_out4  = exp_q[3];
    assign exp_out5  = exp_q[4];
    assign exp_out6  = exp_q[5];
    assign exp_out7  = exp_q[6];
    assign exp_out8  = exp_q[7];
    assign exp_out9  = exp_q[8];
    assign exp_out10 = exp_q[9];

endmodule

// File: tb/tb_subtractors_array.sv
// Directed bench for subtractors_array: expected lane vectors are queued when a
// valid set is driven and popped when out_valid is sampled.
module tb_subtractors_array;

    typedef int arr_t [10];
    typedef logic [9:0][8:0] vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [8:0] exp_sum;
    logic [7:0] xi [10];
    logic       out_valid;
    logic [8:0] eo [10];

    vec_t sb_q[$];
    vec_t last_exp;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    subtractors_array dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .exp_sum   (exp_sum),
        .x1        (xi[0]),
        .x2        (xi[1]),
        .x3        (xi[2]),
        .x4        (xi[3]),
        .x5        (xi[4]),
        .x6        (xi[5]),
        .x7        (xi[6]),
        .x8        (xi[7]),
        .x9        (xi[8]),
        .x10       (xi[9]),
        .out_valid (out_valid),
        .exp_out1  (eo[0]),
        .exp_out2  (eo[1]),
        .exp_out3  (eo[2]),
        .exp_out4  (eo[3]),
        .exp_out5  (eo[4]),
        .exp_out6  (eo[5]),
        .exp_out7  (eo[6]),
        .exp_out8  (eo[7]),
        .exp_out9  (eo[8]),
        .exp_out10 (eo[9])
    );

    // Reference: plain integer difference, clamped at -256.
    function automatic logic [8:0] ref_sub(input int x, input int s);
        int d;
        d = x - s;
        if (d < -256) d = -256;
        return d[8:0];
    endfunction

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int s, input arr_t xv);
        vec_t v;
        in_valid = 1'b1;
        exp_sum  = s[8:0];
        for (int i = 0; i < 10; i++) begin
            xi[i] = xv[i][7:0];
            v[i]  = ref_sub(xv[i], s);
        end
        sb_q.push_back(v);
    endtask

    task automatic drive_idle();
        in_valid = 1'b0;
        exp_sum  = 9'($urandom_range(0, 511));
        for (int i = 0; i < 10; i++) xi[i] = 8'($urandom_range(0, 255));
    endtask

    task automatic chk_valid(input string tag);
        vec_t v;
        chk({tag, ".valid"}, {8'd0, out_valid}, 9'd1);
        total++;
        assert (sb_q.size() != 0) else begin
            bad++;
            $error("FAIL %s.queue observed=empty expected=entry", tag);
        end
        if (sb_q.size() != 0) begin
            v = sb_q.pop_front();
            last_exp = v;
            for (int i = 0; i < 10; i++)
                chk($sformatf("%s.lane%0d", tag, i + 1), eo[i], v[i]);
        end
    endtask

    task automatic chk_hold(input string tag);
        chk({tag, ".valid"}, {8'd0, out_valid}, 9'd0);
        for (int i = 0; i < 10; i++)
            chk($sformatf("%s.lane%0d", tag, i + 1), eo[i], last_exp[i]);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".valid"}, {8'd0, out_valid}, 9'd0);
        for (int i = 0; i < 10; i++)
            chk($sformatf("%s.lane%0d", tag, i + 1), eo[i], 9'd0);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        arr_t xv;

        // reset with random valid-looking inputs
        rst_n    = 1'b0;
        in_valid = 1'b1;
        exp_sum  = 9'($urandom_range(0, 511));
        for (int i = 0; i < 10; i++) xi[i] = 8'($urandom_range(0, 255));
        cycle();
        cycle();
        chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        drive_idle();
        cycle();
        chk_zero("post_reset");

        // nominal set
        xv = '{100, 75, 25, 37, 62, 87, 112, 125, 50, 45};
        drive(50, xv);
        cycle();
        chk_valid("nominal");

        // hold: in_valid low with changed inputs
        drive_idle();
        cycle();
        chk_hold("hold");

        // saturation
        xv = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        drive(511, xv);
        cycle();
        chk_valid("sat511");
        xv = '{255, 255, 255, 255, 255, 255, 255, 255, 255, 255};
        drive(300, xv);
        cycle();
        chk_valid("near_sat");
        xv = '{0, 1, 255, 254, 10, 128, 200, 3, 77, 99};
        drive(256, xv);
        cycle();
        chk_valid("edge256");

        // bounds
        xv = '{255, 0, 1, 128, 200, 17, 254, 64, 99, 3};
        drive(0, xv);
        cycle();
        chk_valid("sum0");
        xv = '{128, 128, 128, 128, 128, 128, 128, 128, 128, 128};
        drive(128, xv);
        cycle();
        chk_valid("equal");

        // back-to-back random sets
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < 10; i++) xv[i] = int'($urandom_range(0, 255));
            drive(int'($urandom_range(0, 511)), xv);
            cycle();
            chk_valid($sformatf("b2b%0d", k));
        end

        drive_idle();
        cycle();
        chk_hold("hold2");

        // async reset between edges while a set is in flight
        xv = '{9, 8, 7, 6, 5, 4, 3, 2, 1, 0};
        drive(3, xv);
        cycle();
        chk_valid("pre_async");
        for (int i = 0; i < 10; i++) xv[i] = int'($urandom_range(0, 255));
        drive(int'($urandom_range(0, 511)), xv);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("async_rst");
        sb_q.delete();
        cycle();
        chk_zero("async_hold");
        @(negedge clk);
        rst_n = 1'b1;
        xv = '{33, 44, 55, 66, 77, 88, 99, 111, 222, 250};
        drive(60, xv);
        cycle();
        chk_valid("recover");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
